// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a fifo onto a UART-style serial line. Whenever the fifo holds a word
//   and tx_en is high, the head word is popped and sent as one start bit (0),
//   WIDTH data bits LSB-first and STOP_BITS stop bits (1), each bit lasting
//   CLKS_PER_BIT clocks. Frames are sent back-to-back while words remain.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   res_n           synchronous active-low reset
//   tx_en           permission to start new frames
//   fifo_empty      fifo empty flag
//   fifo_data       fifo head word, valid while fifo_empty is low
//   fifo_shift_out  one-cycle pop strobe towards the fifo
//   tx              serial line, idles high
//   busy            high while a frame is in START/DATA/STOP
//   frame_done      one-cycle pulse on the last cycle of each stop period

module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_shift_out,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [BAUD_W-1:0]  baud_cnt, baud_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_nxt;
  logic [WIDTH-1:0]   shreg, shreg_nxt;
  logic               baud_last;
  logic               can_pop;
  logic               pop;
  logic               tx_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  // State register. The outputs are registered copies of the values the
  // output logic derives from the next state, so they line up with it.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // Next-state and datapath logic. bit_cnt counts data bits in DATA and
  // stop bits in STOP; it restarts from zero on every state change.
  // can_pop includes res_n so no pop is issued on a reset cycle.
  always_comb begin
    baud_last = (baud_cnt == BAUD_LAST);
    can_pop   = res_n && tx_en && !fifo_empty;
    state_nxt = state;
    pop       = 1'b0;

    unique case (state)
      IDLE: begin
        if (can_pop) begin
          state_nxt = START;
          pop       = 1'b1;
        end
      end
      START: begin
        if (baud_last) state_nxt = DATA;
      end
      DATA: begin
        if (baud_last && (bit_cnt == DATA_LAST)) state_nxt = STOP;
      end
      STOP: begin
        // Reloading straight from the last stop cycle avoids an idle gap.
        if (baud_last && (bit_cnt == STOP_LAST)) begin
          if (can_pop) begin
            state_nxt = START;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if ((state == IDLE) || baud_last) baud_nxt = '0;
    else                              baud_nxt = baud_cnt + BAUD_W'(1);

    if (state_nxt != state) bit_nxt = '0;
    else if (baud_last)     bit_nxt = bit_cnt + BIT_W'(1);
    else                    bit_nxt = bit_cnt;

    if (pop)                            shreg_nxt = fifo_data;
    else if ((state == DATA) && baud_last) shreg_nxt = shreg >> 1;
    else                                shreg_nxt = shreg;
  end

  // Output logic. frame_done is raised for the cycle in which the counters
  // will sit on the final count of the final stop bit.
  always_comb begin
    tx_nxt         = 1'b1;
    busy_nxt       = (state_nxt != IDLE);
    done_nxt       = (state_nxt == STOP) && (baud_nxt == BAUD_LAST) &&
                     (bit_nxt == STOP_LAST);
    fifo_shift_out = pop;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx. A queue-based fifo model feeds the main instance
//   (STOP_BITS=1); every pushed word is also queued as an expected frame. A
//   monitor samples the line each cycle, rebuilds whole frames and compares
//   them with waveforms computed from the expected word. A second instance
//   with STOP_BITS=2 is exercised with a single directed frame.

module tb_fifo_uart_tx;

  localparam int W      = 8;
  localparam int CPB    = 4;
  localparam int FRAME1 = (1 + W + 1) * CPB;
  localparam int FRAME2 = (1 + W + 2) * CPB;

  logic         clk        = 1'b0;
  logic         res_n      = 1'b0;
  logic         tx_en      = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data  = '0;
  logic         fifo_shift_out, tx, busy, frame_done;

  logic         tx_en2   = 1'b0;
  logic         f2_empty = 1'b1;
  logic [W-1:0] f2_data  = '0;
  logic         shift2, tx2, busy2, done2;

  int           n_cmp  = 0;
  int           n_fail = 0;

  logic [W-1:0] words[$];
  logic [W-1:0] exp_q[$];
  int           pop_idx  = 0;
  bit           pop_seen = 1'b0;
  bit           rst_prev = 1'b0;
  bit           in_frame = 1'b0;
  bit           pending  = 1'b0;
  int           idx      = 0;
  int           n_pops   = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .res_n(res_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_shift_out(fifo_shift_out), .tx(tx),
    .busy(busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .res_n(res_n), .tx_en(tx_en2), .fifo_empty(f2_empty),
    .fifo_data(f2_data), .fifo_shift_out(shift2), .tx(tx2),
    .busy(busy2), .frame_done(done2)
  );

  // Line level of a frame at cycle i: start bit, data LSB-first, then stop.
  function automatic logic frame_bit(input logic [W-1:0] w, input int i);
    int b;
    b = i / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return w[b-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic en);
    @(posedge clk);
    #2;
    res_n = rn;
    tx_en = en;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    words.push_back(w);
    exp_q.push_back(w);
  endtask

  // Fifo model: a pop strobe seen before the edge removes the head word.
  task automatic run_fifo();
    forever begin
      @(posedge clk);
      #1;
      if (pop_seen && (pop_idx < words.size())) pop_idx++;
      fifo_empty = (pop_idx >= words.size());
      fifo_data  = fifo_empty ? W'($urandom) : words[pop_idx];
    end
  endtask

  // Monitor: one sample per cycle on the falling edge.
  task automatic run_monitor();
    logic [63:0]  got_tx, got_busy, got_done, exp_tx;
    logic [W-1:0] w;
    bit           exp_pop;
    forever begin
      @(negedge clk);
      if (!rst_prev) begin
        checkOutput("reset_state", 64'({tx, busy, frame_done}), 64'(3'b100));
        if ((in_frame || pending) && (exp_q.size() > 0)) void'(exp_q.pop_front());
        in_frame = 1'b0;
        pending  = 1'b0;
      end else begin
        if (pending) begin
          pending  = 1'b0;
          in_frame = 1'b1;
          idx      = 0;
          got_tx   = '0;
          got_busy = '0;
          got_done = '0;
        end
        if (in_frame) begin
          got_tx[idx]   = tx;
          got_busy[idx] = busy;
          got_done[idx] = frame_done;
          idx++;
          if (idx == FRAME1) begin
            in_frame = 1'b0;
            if (exp_q.size() > 0) begin
              w      = exp_q.pop_front();
              exp_tx = '0;
              for (int i = 0; i < FRAME1; i++) exp_tx[i] = frame_bit(w, i);
              checkOutput("frame_tx", got_tx, exp_tx);
              checkOutput("frame_busy", got_busy, (64'd1 << FRAME1) - 64'd1);
              checkOutput("frame_done", got_done, 64'd1 << (FRAME1 - 1));
            end else begin
              checkOutput("frame_expected", 64'(0), 64'(1));
            end
          end
        end else begin
          checkOutput("idle_line", 64'({tx, busy, frame_done}), 64'(3'b100));
        end
      end
      exp_pop = res_n && tx_en && !fifo_empty && !in_frame && !pending;
      checkOutput("pop_strobe", 64'(fifo_shift_out), 64'(exp_pop));
      pop_seen = fifo_shift_out;
      if (fifo_shift_out) begin
        pending = 1'b1;
        n_pops++;
      end
      rst_prev = res_n;
    end
  endtask

  task automatic wait_drained(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #2;
      if ((pop_idx >= words.size()) && !in_frame && !pending) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, 64'(ok), 64'(1));
  endtask

  task automatic wait_frame_idx(input int min_idx, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #2;
      if (in_frame && (idx >= min_idx)) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, 64'(ok), 64'(1));
  endtask

  task automatic wait_frame_end(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #2;
      if (!in_frame && !pending) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, 64'(ok), 64'(1));
  endtask

  initial begin
    int          n0;
    bit          cur_en;
    bit          ok;
    bit          extra_pop;
    logic [63:0] got2, done2_v, exp2;

    fork
      run_fifo();
      run_monitor();
    join_none

    // Reset held for three cycles.
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0);

    // Single word.
    n0 = n_pops;
    applyStimulus(1'b1, 1'b1);
    push_word(8'hA5);
    wait_drained(200, "drain_single");
    checkOutput("pops_single", 64'(n_pops - n0), 64'(1));

    // Three queued words sent back-to-back.
    n0 = n_pops;
    applyStimulus(1'b1, 1'b1);
    push_word(8'h01);
    push_word(8'hFF);
    push_word(8'h3C);
    wait_drained(400, "drain_three");
    checkOutput("pops_three", 64'(n_pops - n0), 64'(3));

    // tx_en dropped during the data bits of the first of two words.
    applyStimulus(1'b1, 1'b1);
    push_word(8'h5A);
    push_word(8'hC3);
    wait_frame_idx(10, 100, "reach_data");
    applyStimulus(1'b1, 1'b0);
    wait_frame_end(100, "first_frame_end");
    repeat (10) applyStimulus(1'b1, 1'b0);
    checkOutput("held_word", 64'(words.size() - pop_idx), 64'(1));
    checkOutput("held_line", 64'(tx), 64'(1));
    applyStimulus(1'b1, 1'b1);
    wait_drained(200, "drain_resumed");

    // Reset pulse during data bit 3.
    applyStimulus(1'b1, 1'b1);
    push_word(8'h96);
    push_word(8'h4B);
    wait_frame_idx(17, 100, "reach_bit3");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("abort_line", 64'({tx, busy}), 64'(2'b10));
    checkOutput("kept_words", 64'(words.size() - pop_idx), 64'(1));
    applyStimulus(1'b1, 1'b1);
    wait_drained(200, "drain_after_reset");

    // Empty fifo with tx_en high: no pops allowed.
    n0 = n_pops;
    repeat (100) applyStimulus(1'b1, 1'b1);
    checkOutput("pops_empty", 64'(n_pops - n0), 64'(0));

    // Randomised traffic with tx_en toggling and occasional resets.
    cur_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 199) == 0) applyStimulus(1'b0, cur_en);
      else                             applyStimulus(1'b1, cur_en);
      if ($urandom_range(0, 3) == 0) push_word(W'($urandom));
    end
    applyStimulus(1'b1, 1'b1);
    wait_drained(8000, "drain_random");

    // Two stop bits on the second instance.
    applyStimulus(1'b1, 1'b1);
    tx_en2   = 1'b1;
    f2_data  = 8'hA5;
    f2_empty = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (shift2) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("stop2_pop", 64'(ok), 64'(1));
    @(posedge clk);
    #2;
    f2_empty  = 1'b1;
    f2_data   = 8'h00;
    got2      = '0;
    done2_v   = '0;
    exp2      = '0;
    extra_pop = 1'b0;
    for (int i = 0; i < FRAME2; i++) begin
      @(negedge clk);
      got2[i]    = tx2;
      done2_v[i] = done2;
      exp2[i]    = frame_bit(8'hA5, i);
      extra_pop  = extra_pop | shift2;
    end
    checkOutput("stop2_frame", got2, exp2);
    checkOutput("stop2_done", done2_v, 64'd1 << (FRAME2 - 1));
    checkOutput("stop2_extra_pop", 64'(extra_pop), 64'(0));
    @(negedge clk);
    checkOutput("stop2_idle", 64'({tx2, busy2}), 64'(2'b10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
